// File: rtl/lane_sched_pkg.sv
// Shared types and helpers for the lane round-robin scheduler.
// Holds the FSM state encoding, lane-select encoding and pointer-advance helper.
package lane_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  localparam logic LANE_A = 1'b1;
  localparam logic LANE_B = 1'b0;

  // Hold counter must reach HOLD_CYC-1, and HOLD_CYC is at most 15.
  localparam int CNT_W = 4;

  function automatic int rr_next_ptr(input int idx, input int num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Produces a found flag, the winner index and the matching one-hot grant.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic               found,
  output logic [IDXW-1:0]    idx,
  output logic [NUM_REQ-1:0] gnt
);

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[IDXW'(j)]) begin
        found = 1'b1;
        idx   = IDXW'(j);
      end
    end
    if (found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/lane_rr_sched.sv
// Round-robin owner scheduler for the shared dual-lane capture pair.
// Grants one requester per bounded window, pulses capture-enable and alternates A/B lanes.
module lane_rr_sched
  import lane_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_CYC = 2,
  parameter int IDXW     = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_release,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDXW-1:0]    o_gnt_idx,
  output logic               o_gnt_vld,
  output logic               o_cap_en,
  output logic               o_lane_sel,
  output logic               o_busy
);

  sched_state_e       r_state, w_state_nxt;
  logic [IDXW-1:0]    r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDXW-1:0]    r_gnt_idx, w_gnt_idx_nxt;
  logic               r_cap_en, w_cap_en_nxt;
  logic               r_lane_sel, w_lane_sel_nxt;
  logic               r_busy, w_busy_nxt;

  logic               w_pick_found;
  logic [IDXW-1:0]    w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic               w_exit;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDXW   (IDXW)
  ) u_pick (
    .req  (i_req),
    .ptr  (r_ptr),
    .found(w_pick_found),
    .idx  (w_pick_idx),
    .gnt  (w_pick_gnt)
  );

  assign w_exit = (r_cnt == CNT_W'(HOLD_CYC - 1)) || i_release || !i_req[r_gnt_idx];

  // Every output is computed one cycle ahead here so the ports stay purely registered.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_cap_en_nxt   = 1'b0;
    w_lane_sel_nxt = LANE_B;
    w_busy_nxt     = r_busy;
    case (r_state)
      IDLE, GAP: begin
        if (w_pick_found) begin
          w_state_nxt    = OWN;
          w_gnt_nxt      = w_pick_gnt;
          w_gnt_idx_nxt  = w_pick_idx;
          w_ptr_nxt      = IDXW'(rr_next_ptr(int'(w_pick_idx), NUM_REQ));
          w_cnt_nxt      = '0;
          w_cap_en_nxt   = 1'b1;
          w_lane_sel_nxt = LANE_A;
          w_busy_nxt     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      OWN: begin
        w_busy_nxt = 1'b1;
        if (w_exit) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = '0;
        end else begin
          w_cnt_nxt      = r_cnt + CNT_W'(1);
          w_lane_sel_nxt = ~r_lane_sel;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_cap_en   <= 1'b0;
      r_lane_sel <= LANE_B;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_cap_en   <= w_cap_en_nxt;
      r_lane_sel <= w_lane_sel_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_gnt_idx  = r_gnt_idx;
  assign o_gnt_vld  = |r_gnt;
  assign o_cap_en   = r_cap_en;
  assign o_lane_sel = r_lane_sel;
  assign o_busy     = r_busy;

endmodule

// File: doc/lane_rr_sched.md
# lane_rr_sched

Round-robin scheduler that shares one dual-lane capture datapath (two `test_00`-style capture instances behind an A/B output mux) among `NUM_REQ` requesters. It grants one requester at a time for a bounded ownership window, issues a one-cycle capture-enable at the start of each window, and drives the A/B lane-select that alternates every owned cycle. It sits between the requester ports and the shared capture pair at the top level.

## Interface
- `NUM_REQ`, 4: number of requesters. Legal range 2..16.
- `HOLD_CYC`, 2: maximum ownership window in cycles. Legal range 1..15.
- `IDXW`, `$clog2(NUM_REQ)`: width of the grant index. Derived; do not override.

- `i_clk` in 1: single clock; all logic is rising-edge.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_req` in `NUM_REQ`: level request, one bit per requester. Held until granted.
- `i_release` in 1: the current owner ends its window early. Ignored outside OWN.
- `o_gnt` out `NUM_REQ`: one-hot grant, registered. All-zero when there is no owner.
- `o_gnt_idx` out `IDXW`: index of the current owner. Valid only while `o_gnt_vld`=1.
- `o_gnt_vld` out 1: an owner exists; equals the OR of `o_gnt`.
- `o_cap_en` out 1: one-cycle pulse in the first OWN cycle. Loads the shared datapath.
- `o_lane_sel` out 1: mux control for the shared datapath. 1 selects lane A, 0 selects lane B.
- `o_busy` out 1: 1 in OWN and GAP.

## Operation
- FSM states: IDLE, OWN, GAP.
- Reset (async assert) values:
  - state=IDLE and round-robin pointer `ptr`=0.
  - `o_gnt`=0, `o_gnt_idx`=0, `o_gnt_vld`=0.
  - `o_cap_en`=0, `o_lane_sel`=0, `o_busy`=0.
  - hold counter=0.
- IDLE:
  - If any `i_req` is set, pick a winner, go to OWN, and assert `o_gnt`/`o_cap_en` on the next edge.
  - Otherwise stay in IDLE.
- Winner selection: the first set bit of `i_req` scanning upward from `ptr`, with modulo-`NUM_REQ` wrap. On each grant, `ptr` ← winner+1 (mod `NUM_REQ`).
- OWN:
  - The hold counter starts at 0 and increments each cycle.
  - Exit to GAP at the end of the cycle where any of these holds:
    - counter = `HOLD_CYC`-1, or
    - `i_release`=1, or
    - the owner's `i_req` bit is 0.
  - `o_lane_sel` is 1 in the first OWN cycle and toggles every subsequent OWN cycle (A,B,A,...).
- GAP: exactly one cycle, with `o_gnt`=0, `o_lane_sel`=0, `o_busy`=1.
  - Arbitration runs on the current `i_req`.
  - If a winner exists, go to OWN. Otherwise go to IDLE.
- Requests from non-owners during OWN are not lost: they stay pending and are considered in GAP.
- Simultaneous exit conditions in the same cycle give a single exit; the order does not matter.
- `i_req` bit changes during OWN for non-owners have no effect on the current window.
- Reset asserted mid-window: all outputs go to their reset values immediately (async). `ptr` returns to 0.

## Timing
- Request-to-grant latency:
  - From IDLE, 1 cycle: `i_req` sampled at edge N, `o_gnt` high after edge N+1.
  - From GAP, the same 1 cycle.
- Ownership window is 1..`HOLD_CYC` cycles.
- Back-to-back grant period is window + 1 GAP cycle. Two grants are never adjacent.
- `o_cap_en` coincides with the first OWN cycle only. It is never high in GAP or IDLE.
- All outputs are registered with no combinational input-to-output path.
- Deassert of `i_rst` is synchronised externally. The first arbitration happens at the first edge with `i_rst`=1.

## Structure
- Package `lane_sched_pkg` holds:
  - the state enum `sched_state_e` {IDLE, OWN, GAP};
  - the lane encoding constants `LANE_A`=1'b1 and `LANE_B`=1'b0;
  - the function `rr_next_ptr`.
- Sub-module `rr_pick` is a purely combinational round-robin picker.
  - Inputs: `req[NUM_REQ]` and `ptr[IDXW]`.
  - Outputs: `found`, `idx[IDXW]`, and one-hot `gnt[NUM_REQ]`.
  - It is instantiated once in the top FSM.

## Test plan
- Reset then a single request, with `NUM_REQ`=4 and `HOLD_CYC`=2:
  - `i_req`=0100 at cycle 0 gives `o_gnt`=0100, `o_gnt_idx`=2 and `o_cap_en`=1 at cycle 1.
  - `o_lane_sel` is 1,0 over cycles 1–2.
  - GAP at cycle 3, then IDLE.
- All requesting with `i_req`=1111 held gives owners 0,1,2,3,0.
  - Each window is 2 cycles, separated by 1 GAP cycle.
  - `o_cap_en` pulses at cycles 1, 4, 7, 10, 13.
- Early release: requester 1 owns the window and `i_release`=1 in its first OWN cycle. Response:
  - window is 1 cycle;
  - GAP follows next;
  - `ptr`=2.
- Request drop: with `HOLD_CYC`=4, the owner drops `i_req` in OWN cycle 2. Response:
  - exit to GAP after that cycle;
  - no further `o_lane_sel` toggles.
- Async reset mid-OWN: assert `i_rst`=0 between edges. Response:
  - `o_gnt`=0, `o_busy`=0, `o_lane_sel`=0 immediately;
  - after release, `i_req`=1001 grants requester 0 first.
- Wrap: with `ptr`=3 after requester 2's grant and `i_req`=0011, requester 0 wins, then requester 1, then requester 0.
